// File: rtl/audio_recorder.sv
// Segment audio recorder: decimates the ADC stream to one 6-bit sample every
// DIV+1 clocks and writes it into a selected address window of the audio RAM.
module audio_recorder #(
    parameter int unsigned DIV        = 2000,
    parameter int unsigned SEG0_START = 0,
    parameter int unsigned SEG0_END   = 27100,
    parameter int unsigned SEG1_START = 27101,
    parameter int unsigned SEG1_END   = 43830,
    parameter int unsigned SEG2_START = 43831,
    parameter int unsigned SEG2_END   = 54300
) (
    input  logic        CLOCK_50,
    input  logic [0:0]  KEY,
    input  logic [5:3]  SW,
    input  logic        rec_start,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    output logic        read_audio_in,
    output logic [15:0] ram_address,
    output logic [5:0]  ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam logic [15:0] DIV16 = 16'(DIV);
    localparam logic [15:0] S0S   = 16'(SEG0_START);
    localparam logic [15:0] S0E   = 16'(SEG0_END);
    localparam logic [15:0] S1S   = 16'(SEG1_START);
    localparam logic [15:0] S1E   = 16'(SEG1_END);
    localparam logic [15:0] S2S   = 16'(SEG2_START);
    localparam logic [15:0] S2E   = 16'(SEG2_END);

    typedef enum logic [1:0] {IDLE, RECORD, FINISH} state_t;
    state_t state, state_next;

    logic [15:0] cyc, cyc_next, start_addr, start_next, end_addr, end_next, addr_next;
    logic [15:0] sel_start, sel_end;
    logic [5:0]  sample_reg, sample_next, data_next;
    logic        sel_valid, tick, tick_next, fresh, fresh_next;
    logic        wren_next, busy_next, done_next, underrun_next;
    logic        unused_bits;

    assign read_audio_in = audio_in_available;
    assign unused_bits   = ^left_channel_audio_in[25:0];

    always_comb begin
        sel_valid = 1'b1;
        sel_start = '0;
        sel_end   = '0;
        if (SW[5]) begin
            sel_start = S0S;
            sel_end   = S0E;
        end else if (SW[4]) begin
            sel_start = S1S;
            sel_end   = S1E;
        end else if (SW[3]) begin
            sel_start = S2S;
            sel_end   = S2E;
        end else begin
            sel_valid = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            state       <= IDLE;
            cyc         <= '0;
            tick        <= 1'b0;
            fresh       <= 1'b0;
            sample_reg  <= '0;
            start_addr  <= '0;
            end_addr    <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_next;
            cyc         <= cyc_next;
            tick        <= tick_next;
            fresh       <= fresh_next;
            sample_reg  <= sample_next;
            start_addr  <= start_next;
            end_addr    <= end_next;
            ram_address <= addr_next;
            ram_data    <= data_next;
            ram_wren    <= wren_next;
            busy        <= busy_next;
            done        <= done_next;
            underrun    <= underrun_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rec_start && sel_valid) state_next = RECORD;
            RECORD:  if (ram_wren && ram_address == end_addr) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tick marks the interval boundary; the RAM write is issued one edge later
    always_comb begin
        cyc_next      = cyc;
        tick_next     = 1'b0;
        fresh_next    = fresh;
        sample_next   = sample_reg;
        start_next    = start_addr;
        end_next      = end_addr;
        addr_next     = ram_address;
        data_next     = ram_data;
        wren_next     = 1'b0;
        underrun_next = underrun;
        busy_next     = (state_next == RECORD);
        done_next     = (state_next == FINISH);
        case (state)
            IDLE: begin
                if (state_next == RECORD) begin
                    start_next    = sel_start;
                    end_next      = sel_end;
                    addr_next     = sel_start;
                    cyc_next      = '0;
                    underrun_next = 1'b0;
                end
            end
            RECORD: begin
                if (cyc == DIV16) begin
                    cyc_next  = '0;
                    tick_next = 1'b1;
                end else begin
                    cyc_next = cyc + 16'd1;
                end
                if (tick) begin
                    wren_next  = 1'b1;
                    data_next  = sample_reg;
                    fresh_next = 1'b0;
                    if (!fresh) underrun_next = 1'b1;
                end
                if (ram_wren && ram_address != end_addr) addr_next = ram_address + 16'd1;
            end
            default: ;
        endcase
        // a new sample on the write cycle counts as fresh for the next write
        if (audio_in_available) begin
            sample_next = left_channel_audio_in[31:26];
            fresh_next  = 1'b1;
        end
    end
endmodule
